// File: rtl/alu_share_scheduler_if.sv
// alu_share_scheduler_if: request, shared-unit and response signals of the
// ALU share scheduler. The scheduler uses the slave modport; requesters,
// the shared logic unit and the response consumer sit on the master side.
interface alu_share_scheduler_if;
    logic       req0_valid;
    logic [1:0] req0_op;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req0_ready;

    logic       req1_valid;
    logic [1:0] req1_op;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req1_ready;

    logic [1:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_y;

    logic       rsp_valid;
    logic       rsp_id;
    logic [3:0] rsp_y;
    logic       rsp_ready;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_y,
        output rsp_valid, rsp_id, rsp_y,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_y,
        input  rsp_valid, rsp_id, rsp_y,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_scheduler.sv
// alu_share_scheduler: shares one combinational 4-bit logic unit between two
// requesters, one transaction in flight at a time. The unit is given
// WAIT_CYCLES cycles to settle before its result is sampled.
// Build option: define ALU_SHARE_RR_EN for round-robin arbitration between
// the requesters; left undefined, requester 0 has fixed priority.
//
// state | meaning
// IDLE  | no transaction; arbiter may grant one requester
// EXEC  | operands held on alu_*; settle counter running down to zero
// RESP  | result held on rsp_*; waiting for rsp_ready
module alu_share_scheduler #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_share_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter is loaded with WAIT_CYCLES-1 so that EXEC spans exactly
    // WAIT_CYCLES edges, the last one being the terminal count.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       last_id;
    logic       rsp_valid_q;
    logic       rsp_id_q;
    logic [3:0] rsp_y_q;

    logic       pick1;
    logic       grant0;
    logic       grant1;
    logic       accept;

`ifdef ALU_SHARE_RR_EN
    // On contention serve whichever requester was not served last.
    assign pick1 = ~last_id;
`else
    // On contention requester 0 always wins.
    assign pick1 = 1'b0;
`endif

    // Arbiter: grant only in IDLE and never while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = ~pick1;
                grant1 = pick1;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign accept         = grant0 | grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    assign bus.alu_op    = (state == IDLE) ? 2'b00 : op_q;
    assign bus.alu_a     = (state == IDLE) ? 4'h0  : a_q;
    assign bus.alu_b     = (state == IDLE) ? 4'h0  : b_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;

    // Sequencer: capture on accept, settle in EXEC, hold result in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'h0;
            op_q        <= 2'b00;
            a_q         <= 4'h0;
            b_q         <= 4'h0;
            last_id     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= 4'h0;
        end else begin
            // Arbiter history moves only on an accept.
            last_id <= accept ? grant1 : last_id;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= grant1 ? bus.req1_op : bus.req0_op;
                        a_q      <= grant1 ? bus.req1_a  : bus.req0_a;
                        b_q      <= grant1 ? bus.req1_b  : bus.req0_b;
                        rsp_id_q <= grant1;
                        cnt      <= CNT_LOAD;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'h0) begin
                        rsp_y_q     <= bus.alu_y;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'h1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_scheduler.sv
// tb_alu_share_scheduler: three schedulers (WAIT_CYCLES 2, 1, 15) each with a
// behavioural shared unit. Vector table plus hand-written sequences; a
// scoreboard checks every response against the accepted request.
module tb_alu_share_scheduler;

`ifdef ALU_SHARE_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       r0v, r1v, rr, r0r, r1r, rv, rid;
    logic [2:0][1:0]  r0op, r1op, aop;
    logic [2:0][3:0]  r0a, r0b, r1a, r1b, ry, aa, ab;

    int errors = 0;
    int checks = 0;
    int cur = 0;

    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a ^ b);
            default: return a ^ b;
        endcase
    endfunction

    function automatic int wl(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 15;
    endfunction

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : gd
            localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 15;
            alu_share_scheduler_if bus ();
            alu_share_scheduler #(.WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus));
            assign bus.req0_valid = r0v[g];
            assign bus.req0_op    = r0op[g];
            assign bus.req0_a     = r0a[g];
            assign bus.req0_b     = r0b[g];
            assign bus.req1_valid = r1v[g];
            assign bus.req1_op    = r1op[g];
            assign bus.req1_a     = r1a[g];
            assign bus.req1_b     = r1b[g];
            assign bus.rsp_ready  = rr[g];
            assign bus.alu_y      = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
            assign r0r[g] = bus.req0_ready;
            assign r1r[g] = bus.req1_ready;
            assign rv[g]  = bus.rsp_valid;
            assign rid[g] = bus.rsp_id;
            assign ry[g]  = bus.rsp_y;
            assign aop[g] = bus.alu_op;
            assign aa[g]  = bus.alu_a;
            assign ab[g]  = bus.alu_b;
        end
    endgenerate

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard for the instance selected by cur.
    typedef struct { logic id; logic [3:0] y; } exp_t;
    exp_t sbq[$];
    logic mlast = 1'b1;

    // Monitor: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        logic a0, a1, eg;
        exp_t e;
        if (rst) begin
            sbq.delete();
            mlast = 1'b1;
        end else begin
            if (rv[cur] && rr[cur]) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_rsp: got response id=%0d y=%0h with nothing expected", rid[cur], ry[cur]);
                end else begin
                    e = sbq.pop_front();
                    check("sb_rsp_id", int'(rid[cur]), int'(e.id));
                    check("sb_rsp_y", int'(ry[cur]), int'(e.y));
                end
            end
            a0 = r0v[cur] && r0r[cur];
            a1 = r1v[cur] && r1r[cur];
            if (a0 || a1) begin
                check("sb_single_grant", int'(a0 && a1), 0);
                if (r0v[cur] && r1v[cur]) eg = RR ? ~mlast : 1'b0;
                else                      eg = r1v[cur];
                check("sb_grant_id", int'(a1), int'(eg));
                e.id = a1;
                e.y  = a1 ? alu_f(r1op[cur], r1a[cur], r1b[cur]) : alu_f(r0op[cur], r0a[cur], r0b[cur]);
                sbq.push_back(e);
                mlast = a1;
            end
        end
    end

    typedef struct { logic [1:0] op; logic [3:0] a; logic [3:0] b; logic [3:0] y; } vec_t;
    vec_t tbl [17];

    // One requester-0 transaction on instance k with rsp_ready high.
    task automatic do_one(input int k, input vec_t v);
        int n;
        int lat;
        @(posedge clk); #1;
        r0v[k] = 1'b1; r0op[k] = v.op; r0a[k] = v.a; r0b[k] = v.b;
        n = 0;
        do begin @(negedge clk); n++; end while (!r0r[k] && n < 20);
        check("vec_ready_seen", int'(r0r[k]), 1);
        @(posedge clk); #1;
        r0v[k] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rv[k] && lat < 40);
        // rsp_valid rises WAIT_CYCLES edges after accept: seen on negedge WAIT_CYCLES+1.
        check("vec_latency", lat, wl(k) + 1);
        check("vec_rsp_y", int'(ry[k]), int'(v.y));
        check("vec_rsp_id", int'(rid[k]), 0);
    endtask

    task automatic reset_to(input int k);
        @(posedge clk); #1;
        rst = 1'b1;
        cur = k;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int ids[4];
        int ys[4];
        int accn[4];
        int na, nr, n;
        bit saw_r1, saw_rv;
        logic [3:0] hy;

        tbl[0]  = '{2'b10, 4'b1010, 4'b0110, 4'b0011};
        tbl[1]  = '{2'b00, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{2'b00, 4'h0, 4'hF, 4'h0};
        tbl[3]  = '{2'b00, 4'hF, 4'h0, 4'h0};
        tbl[4]  = '{2'b00, 4'hF, 4'hF, 4'hF};
        tbl[5]  = '{2'b01, 4'h0, 4'h0, 4'h0};
        tbl[6]  = '{2'b01, 4'h0, 4'hF, 4'hF};
        tbl[7]  = '{2'b01, 4'hF, 4'h0, 4'hF};
        tbl[8]  = '{2'b01, 4'hF, 4'hF, 4'hF};
        tbl[9]  = '{2'b10, 4'h0, 4'h0, 4'hF};
        tbl[10] = '{2'b10, 4'h0, 4'hF, 4'h0};
        tbl[11] = '{2'b10, 4'hF, 4'h0, 4'h0};
        tbl[12] = '{2'b10, 4'hF, 4'hF, 4'hF};
        tbl[13] = '{2'b11, 4'h0, 4'h0, 4'h0};
        tbl[14] = '{2'b11, 4'h0, 4'hF, 4'hF};
        tbl[15] = '{2'b11, 4'hF, 4'h0, 4'hF};
        tbl[16] = '{2'b11, 4'hF, 4'hF, 4'h0};

        r1v = '0; rr = '1;
        r0op = '0; r0a = '0; r0b = '0; r1op = '0; r1a = '0; r1b = '0;
        // Requests pending during reset must not be granted.
        r0v = 3'b111; r1v = 3'b111;
        r0op[0] = 2'b00; r0a[0] = 4'b1111; r0b[0] = 4'b0000;
        r1op[0] = 2'b01; r1a[0] = 4'b1100; r1b[0] = 4'b1010;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_req0_ready", int'(r0r[k]), 0);
            check("rst_req1_ready", int'(r1r[k]), 0);
            check("rst_rsp_valid", int'(rv[k]), 0);
            check("rst_rsp_id", int'(rid[k]), 0);
            check("rst_rsp_y", int'(ry[k]), 0);
            check("rst_alu_op", int'(aop[k]), 0);
            check("rst_alu_a", int'(aa[k]), 0);
        end

        // Both requesters on instance 0 hold valid continuously from reset release.
        @(posedge clk); #1;
        rst = 1'b0;
        r0v[2:1] = 2'b00; r1v[2:1] = 2'b00;
        na = 0; nr = 0; n = 0; saw_r1 = 1'b0;
        while (nr < 4 && n < 80) begin
            @(negedge clk);
            if (r1r[0]) saw_r1 = 1'b1;
            if (((r0v[0] && r0r[0]) || (r1v[0] && r1r[0])) && na < 4) begin
                accn[na] = n;
                ids[na] = int'(r1r[0]);
                na++;
            end
            if (rv[0] && rr[0]) begin
                ys[nr] = int'(ry[0]);
                nr++;
            end
            n++;
        end
        @(posedge clk); #1;
        r0v[0] = 1'b0; r1v[0] = 1'b0;
        check("both_rsp_count", nr, 4);
        check("both_accept_count", na, 4);
        check("both_first_accept_after_rst", accn[0], 0);
        for (int i = 0; i < 4; i++) begin
            check("both_grant_id", ids[i], (RR && (i % 2 == 1)) ? 1 : 0);
            check("both_rsp_y", ys[i], (RR && (i % 2 == 1)) ? 4'b1110 : 4'b0000);
            if (i > 0) check("both_accept_spacing", accn[i] - accn[i-1], wl(0) + 2);
        end
        if (!RR) check("fixed_req1_never_ready", int'(saw_r1), 0);
        repeat (6) @(posedge clk);

        for (int i = 0; i < 5; i++) do_one(0, tbl[i]);

        reset_to(1);
        for (int i = 1; i < 17; i++) do_one(1, tbl[i]);

        reset_to(2);
        for (int i = 1; i < 17; i++) do_one(2, tbl[i]);

        // Consumer stalls five cycles while a response is pending.
        reset_to(0);
        @(posedge clk); #1;
        rr[0] = 1'b0;
        r0v[0] = 1'b1; r0op[0] = 2'b11; r0a[0] = 4'b0101; r0b[0] = 4'b0011;
        n = 0;
        do begin @(negedge clk); n++; end while (!r0r[0] && n < 20);
        check("stall_ready_seen", int'(r0r[0]), 1);
        @(posedge clk); #1;
        r0v[0] = 1'b1; r1v[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rv[0] && n < 40);
        check("stall_rsp_valid_seen", int'(rv[0]), 1);
        hy = ry[0];
        check("stall_rsp_y", int'(hy), 4'b0110);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid_held", int'(rv[0]), 1);
            check("stall_rsp_y_held", int'(ry[0]), int'(hy));
            check("stall_rsp_id_held", int'(rid[0]), 0);
            check("stall_readies_low", int'({r0r[0], r1r[0]}), 0);
        end
        @(posedge clk); #1;
        rr[0] = 1'b1; r0v[0] = 1'b0; r1v[0] = 1'b0;
        @(negedge clk);
        check("stall_valid_before_release_edge", int'(rv[0]), 1);
        @(negedge clk);
        check("stall_valid_dropped", int'(rv[0]), 0);
        repeat (4) @(posedge clk);

        // Reset pulse in the middle of a long EXEC on instance 2.
        reset_to(2);
        @(posedge clk); #1;
        r0v[2] = 1'b1; r0op[2] = 2'b01; r0a[2] = 4'b0011; r0b[2] = 4'b0101;
        n = 0;
        do begin @(negedge clk); n++; end while (!r0r[2] && n < 20);
        check("midrst_ready_seen", int'(r0r[2]), 1);
        @(posedge clk); #1;
        r0v[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rsp_valid", int'(rv[2]), 0);
        check("midrst_rsp_id", int'(rid[2]), 0);
        check("midrst_rsp_y", int'(ry[2]), 0);
        check("midrst_alu_a_idle", int'(aa[2]), 0);
        saw_rv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rv[2]) saw_rv = 1'b1;
        end
        check("midrst_no_response", int'(saw_rv), 0);
        @(posedge clk); #1;
        r0v[2] = 1'b1; r0op[2] = 2'b00; r0a[2] = 4'b1001; r0b[2] = 4'b1100;
        r1v[2] = 1'b1; r1op[2] = 2'b11; r1a[2] = 4'b0001; r1b[2] = 4'b0001;
        @(negedge clk);
        check("midrst_grant0_ready", int'(r0r[2]), 1);
        check("midrst_grant1_ready", int'(r1r[2]), 0);
        @(posedge clk); #1;
        r0v[2] = 1'b0; r1v[2] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_scheduler.md
ALU_SHARE_SCHEDULER -- requirements
Module: alu_share_scheduler

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, settle cycles allowed for shared 4-bit logic unit before result sampled (legal 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_op  input  2  requester 0 opcode (00 AND, 01 OR, 10 XNOR, 11 XOR).
REQ-006 req0_a, req0_b  input  4 each  requester 0 operands.
REQ-007 req0_ready  output  1  requester 0 accepted this cycle when high with req0_valid.
REQ-008 req1_valid, req1_op, req1_a, req1_b, req1_ready: same as REQ-004..007 for requester 1.
REQ-009 alu_op  output  2  opcode to shared unit.
REQ-010 alu_a, alu_b  output  4 each  operands to shared unit.
REQ-011 alu_y  input  4  shared-unit result.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_id  output  1  requester owning result (0/1).
REQ-014 rsp_y  output  4  captured result.
REQ-015 rsp_ready  input  1  consumer accepts result when high with rsp_valid.

Function
REQ-016 FSM states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-017 IDLE: reqN_ready high (combinational) only for requester selected by arbiter this cycle; other ready low; both low if neither valid.
REQ-018 Transfer on edge where reqN_valid & reqN_ready: op/a/b/id captured, counter loaded WAIT_CYCLES-1, IDLE->EXEC.
REQ-019 EXEC/RESP: alu_op/alu_a/alu_b driven from captured registers; IDLE: driven 0.
REQ-020 EXEC: counter decrements each cycle; on edge with counter==0, alu_y captured into rsp_y, EXEC->RESP; EXEC lasts exactly WAIT_CYCLES cycles.
REQ-021 Latency: rsp_valid rises WAIT_CYCLES edges after accept edge.
REQ-022 RESP: rsp_valid=1, rsp_y/rsp_id stable until rsp_ready sampled high; then RESP->IDLE, rsp_valid=0 next cycle.
REQ-023 reqN_ready low in EXEC and RESP regardless of reqN_valid; requests held by requester, never dropped.
REQ-024 Minimum spacing between accepts: WAIT_CYCLES+2 cycles (rsp_ready tied high).
REQ-025 Arbiter pointer last_id updated on every accept; no update without accept.
REQ-026 Change of reqN_* while not granted has no effect on state.

Reset
REQ-027 rst high at any edge, in any state (including mid-EXEC/RESP): state=IDLE, rsp_valid=0, rsp_id=0, rsp_y=0, captured op/a/b=0, counter=0, last_id=1; in-flight transaction discarded, no response issued.
REQ-028 During rst cycle both reqN_ready low; first accept possible on first edge after rst deasserted.

Configuration
REQ-029 Macro ALU_SHARE_RR_EN defined: round-robin; both valid -> grant requester != last_id (after reset requester 0 first); one valid -> grant it.
REQ-030 ALU_SHARE_RR_EN undefined: fixed priority; requester 0 always wins when both valid; last_id still maintained but unused.

Verification (bench models shared unit as op-decoded combinational logic on alu_*)
REQ-031 req0 only, op=10, a=1010, b=0110, WAIT_CYCLES=2, rsp_ready=1 -> accept edge T, rsp_valid at T+2, rsp_y=0011, rsp_id=0.
REQ-032 RR_EN, both valid continuously, req0 a=1111 b=0000 op=00, req1 a=1100 b=1010 op=01 -> grants 0,1,0,1; rsp_y alternates 0000,1110.
REQ-033 rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_y, rsp_id held; both reqN_ready low; IDLE one edge after rsp_ready high.
REQ-034 rst pulsed one cycle mid-EXEC -> next cycle IDLE, rsp_valid=0, no response for dropped op; next both-valid grants requester 0.
REQ-035 RR_EN undefined, both valid continuously -> requester 0 granted every transaction, req1_ready never high.
REQ-036 WAIT_CYCLES=1 and 15: rsp_valid exactly 1 / 15 edges after accept; all 16 opcode/operand corners (a,b in {0000,1111}) match model.
